// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine: a latched 128-bit state is transformed
// COLS_PER_CYCLE columns per clock and the result is held under backpressure.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int NUM_CYC = 4 / COLS_PER_CYCLE;
  // A 2-bit column step; with four columns per clock the counter never leaves 0.
  localparam logic [1:0] LP_STEP = (COLS_PER_CYCLE == 4) ? 2'd0 : 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LP_LAST = 2'(NUM_CYC - 1);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [1:0]     r_cnt;
  logic [127:0]   r_work;
  logic           r_inv;
  logic [127:0]   r_state_out;
  logic           r_out_valid;
  logic           r_busy;

  logic [6:0]     w_lsb   [COLS_PER_CYCLE];
  logic [31:0]    w_mixed [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 of a column is its most significant byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic mode);
    logic [7:0] s  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] o  [4];
    logic [1:0] r0;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [1:0] r3;
    s[0] = col[31:24];
    s[1] = col[23:16];
    s[2] = col[15:8];
    s[3] = col[7:0];
    for (int i = 0; i < 4; i++) begin
      x2[i] = xtime(s[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int r = 0; r < 4; r++) begin
      r0 = 2'(r);
      r1 = r0 + 2'd1;
      r2 = r0 + 2'd2;
      r3 = r0 + 2'd3;
      if (mode) begin
        o[r] = (x8[r0] ^ x4[r0] ^ x2[r0]) ^ (x8[r1] ^ x2[r1] ^ s[r1])
             ^ (x8[r2] ^ x4[r2] ^ s[r2]) ^ (x8[r3] ^ s[r3]);
      end else begin
        o[r] = x2[r0] ^ (x2[r1] ^ s[r1]) ^ s[r2] ^ s[r3];
      end
    end
    return {o[0], o[1], o[2], o[3]};
  endfunction

  generate
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      logic [1:0] w_idx;
      assign w_idx      = (r_cnt * LP_STEP) + 2'(g);
      // Column c sits at bits [127-32c -: 32], so its LSB is 32*(3-c).
      assign w_lsb[g]   = {~w_idx, 5'd0};
      assign w_mixed[g] = mix_col(r_work[w_lsb[g] +: 32], r_inv);
    end
  endgenerate

  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign out_valid = r_out_valid;
  assign state_out = r_state_out;
  assign busy      = r_busy;

  // Control FSM, working/mode registers and the column-by-column result writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 2'd0;
      r_work      <= 128'd0;
      r_inv       <= 1'b0;
      r_state_out <= 128'd0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_work  <= state_in;
            r_inv   <= inv;
            r_cnt   <= 2'd0;
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            r_state_out[w_lsb[k] +: 32] <= w_mixed[k];
          end
          if (r_cnt == LP_LAST) begin
            r_cnt       <= 2'd0;
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              r_work  <= state_in;
              r_inv   <= inv;
              r_cnt   <= 2'd0;
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= 2'd0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Self-checking bench for mix_columns_engine: three instances (1/2/4 columns per
// clock) checked against a GF(2^8) matrix-multiply reference model.
module tb_mix_columns_engine;

  logic         clk;
  logic         reset;
  logic         in_valid_a  [3];
  logic         in_ready_a  [3];
  logic [127:0] state_in_a  [3];
  logic         inv_a       [3];
  logic         out_valid_a [3];
  logic         out_ready_a [3];
  logic [127:0] state_out_a [3];
  logic         busy_a      [3];

  int n_checks = 0;
  int n_fail   = 0;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_engine #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_a[g]),
        .in_ready  (in_ready_a[g]),
        .state_in  (state_in_a[g]),
        .inv       (inv_a[g]),
        .out_valid (out_valid_a[g]),
        .out_ready (out_ready_a[g]),
        .state_out (state_out_a[g]),
        .busy      (busy_a[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Plain shift-and-add multiply modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] aa;
    logic [7:0] p;
    aa = {1'b0, a};
    p  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa[7:0];
      aa = {aa[7:0], 1'b0};
      if (aa[8]) aa = aa ^ 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic mode);
    logic [7:0]   coef [4];
    logic [7:0]   m    [4][4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (mode) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else      coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[c][r] = 8'(s >> (120 - 32 * c - 8 * r));
    res = 128'd0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[j], m[c][(r + j) % 4]);
        res = res | (128'(acc) << (120 - 32 * c - 8 * r));
      end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Send one block to an idle instance, wait for the result, then pop it.
  task automatic run_block(input int k, input logic [127:0] data, input logic mode,
                           input bit toggle, output logic [127:0] res, output int lat);
    in_valid_a[k]  = 1'b1;
    state_in_a[k]  = data;
    inv_a[k]       = mode;
    out_ready_a[k] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[k] = 1'b0;
    state_in_a[k] = rnd128();
    lat = 1;
    while (!out_valid_a[k] && lat < 20) begin
      if (toggle) inv_a[k] = ~inv_a[k];
      state_in_a[k] = rnd128();
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_timeout", 128'(out_valid_a[k]), 128'd1);
    res = state_out_a[k];
    out_ready_a[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[k] = 1'b0;
  endtask

  logic [127:0] res;
  logic [127:0] res2;
  logic [127:0] data;
  logic [127:0] snap;
  logic [127:0] stream [4];
  int           lat;
  int           lat_exp [3] = '{5, 3, 2};

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid_a[k]  = 1'b0;
      state_in_a[k]  = 128'd0;
      inv_a[k]       = 1'b0;
      out_ready_a[k] = 1'b0;
    end
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_state_out", state_out_a[k], 128'd0);
      check("rst_out_valid", 128'(out_valid_a[k]), 128'd0);
      check("rst_busy", 128'(busy_a[k]), 128'd0);
    end
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) check("rst_in_ready", 128'(in_ready_a[k]), 128'd1);
    @(posedge clk); #1;

    // Known-answer forward vector and latency on the 1-column instance.
    run_block(0, 128'hdb135345_f20a225c_01010101_2d26314c, 1'b0, 1'b0, res, lat);
    check("fwd_kat", res, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
    check_int("fwd_kat_latency", lat, 5);

    // FIPS-197 round 1 on all three widths.
    for (int k = 0; k < 3; k++) begin
      run_block(k, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 1'b0, res, lat);
      check("fips_round1", res, 128'h046681e5_e0cb199a_48f8d37a_2806264c);
      check_int("fips_latency", lat, lat_exp[k]);
    end

    // Known-answer inverse vector.
    run_block(0, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b1, 1'b0, res, lat);
    check("inv_kat", res, 128'hdb135345_f20a225c_01010101_2d26314c);

    // Random forward then inverse round trips across the three widths.
    for (int i = 0; i < 2000; i++) begin
      data = rnd128();
      run_block(i % 3, data, 1'b0, 1'b0, res, lat);
      check("rand_fwd", res, model(data, 1'b0));
      run_block((i + 1) % 3, res, 1'b1, 1'b0, res2, lat);
      check("rand_roundtrip", res2, data);
    end

    // Backpressure: hold the result, refuse new input, then accept in the pop cycle.
    data = rnd128();
    for (int s = 0; s < 4; s++) stream[s] = rnd128();
    in_valid_a[0] = 1'b1; state_in_a[0] = data; inv_a[0] = 1'b0; out_ready_a[0] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    lat = 1;
    while (!out_valid_a[0] && lat < 20) begin @(posedge clk); #1; lat++; end
    check("bp_first_valid", 128'(out_valid_a[0]), 128'd1);
    snap = state_out_a[0];
    check("bp_first_result", snap, model(data, 1'b0));
    in_valid_a[0] = 1'b1; state_in_a[0] = stream[0];
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_hold_data", state_out_a[0], snap);
      check("bp_hold_valid", 128'(out_valid_a[0]), 128'd1);
      check("bp_hold_in_ready", 128'(in_ready_a[0]), 128'd0);
    end
    out_ready_a[0] = 1'b1;
    #1;
    check("bp_same_cycle_ready", 128'(in_ready_a[0]), 128'd1);
    @(posedge clk); #1;
    begin
      int  t, sent, got, last;
      bit  acc, pop;
      t = 0; sent = 1; got = 0; last = 0;
      state_in_a[0] = stream[1];
      while (got < 4 && t < 100) begin
        acc = in_valid_a[0] && in_ready_a[0];
        pop = out_valid_a[0];
        if (pop) begin
          check("stream_result", state_out_a[0], model(stream[got], 1'b0));
          if (got > 0) check_int("stream_interval", t - last, 5);
          last = t;
          got++;
        end
        @(posedge clk); #1;
        t++;
        if (acc) begin
          sent++;
          if (sent < 4) state_in_a[0] = stream[sent];
          else          in_valid_a[0] = 1'b0;
        end
      end
      check_int("stream_count", got, 4);
    end
    out_ready_a[0] = 1'b0;
    in_valid_a[0]  = 1'b0;
    @(posedge clk); #1;

    // Mode is latched at accept; toggling inv afterwards has no effect.
    data = rnd128();
    run_block(0, data, 1'b0, 1'b1, res, lat);
    check("mode_latch_fwd", res, model(data, 1'b0));
    data = {32'hc6c6c6c6, $urandom, $urandom, $urandom};
    run_block(1, data, 1'b0, 1'b1, res, lat);
    check("col0_c6", 128'(res[127:96]), 128'h c6c6c6c6);
    check("col0_c6_full", res, model(data, 1'b0));
    data = {32'hd4d4d4d5, $urandom, $urandom, $urandom};
    run_block(2, data, 1'b0, 1'b0, res, lat);
    check("col0_d4", 128'(res[127:96]), 128'hd5d5d7d6);

    // Asynchronous reset two cycles into a block.
    in_valid_a[0] = 1'b1; state_in_a[0] = rnd128(); inv_a[0] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy_before_reset", 128'(busy_a[0]), 128'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_state_out", state_out_a[0], 128'd0);
    check("async_rst_out_valid", 128'(out_valid_a[0]), 128'd0);
    check("async_rst_busy", 128'(busy_a[0]), 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", 128'(in_ready_a[0]), 128'd1);
    data = rnd128();
    run_block(0, data, 1'b1, 1'b0, res, lat);
    check("post_rst_result", res, model(data, 1'b1));
    check_int("post_rst_latency", lat, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
